// File: rtl/matmul_lanes_seq_pkg.sv
// Shared definitions for the lane-parallel float32 matrix multiplier:
// element width, the +0.0 constant, FSM state encoding and a ceil-division
// helper used to size the column-group sweep.
package matmul_lanes_seq_pkg;

   localparam int          FP_W    = 32;
   localparam logic [31:0] FP_ZERO = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MAC   = 2'd1,
      S_STORE = 2'd2
   } state_e;

   // ceil(a / b) for positive operands
   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/matmul_lanes_seq_fp_mac_lane.sv
// One multiply-accumulate lane: acc <= acc + a*b per enabled cycle.
// The float32 multiplier and adder are combinational, round-to-nearest-even;
// subnormal inputs and results are flushed to signed zero.
module fp_mac_lane
   import matmul_lanes_seq_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic            en,
   input  logic [FP_W-1:0] a,
   input  logic [FP_W-1:0] b,
   output logic [FP_W-1:0] acc
);

   logic [FP_W-1:0] acc_q, acc_d;

   function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
      logic               s, x_nan, y_nan, x_inf, y_inf, x_z, y_z, g, st;
      logic [47:0]        p;
      logic signed [10:0] e;
      logic [22:0]        m;
      logic [24:0]        r;
      logic [31:0]        res;
      s     = x[31] ^ y[31];
      x_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
      y_nan = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
      x_inf = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
      y_inf = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
      x_z   = (x[30:23] == 8'd0);
      y_z   = (y[30:23] == 8'd0);
      p     = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
      e     = 11'(x[30:23]) + 11'(y[30:23]) - 11'd127;
      if (p[47]) begin
         m  = p[46:24];
         g  = p[23];
         st = |p[22:0];
         e  = e + 11'sd1;
      end else begin
         m  = p[45:23];
         g  = p[22];
         st = |p[21:0];
      end
      r = {2'b01, m} + {24'd0, g & (st | m[0])};
      if (r[24]) begin
         e = e + 11'sd1;
         m = r[23:1];
      end else begin
         m = r[22:0];
      end
      if (x_nan || y_nan || (x_inf && y_z) || (y_inf && x_z)) res = 32'h7FC0_0000;
      else if (x_inf || y_inf)                                 res = {s, 8'hFF, 23'd0};
      else if (x_z || y_z)                                     res = {s, 31'd0};
      else if (e >= 11'sd255)                                  res = {s, 8'hFF, 23'd0};
      else if (e <= 11'sd0)                                    res = {s, 31'd0};
      else                                                     res = {s, e[7:0], m};
      return res;
   endfunction

   function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
      logic              x_nan, y_nan, x_inf, y_inf, x_z, y_z, zero_res;
      logic [31:0]       big, sml, res;
      logic [7:0]        d;
      logic [26:0]       mb, ms, msh, nrm;
      logic [27:0]       sum;
      logic [4:0]        lz;
      logic signed [9:0] e;
      logic [24:0]       r;
      logic [22:0]       m;
      x_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
      y_nan = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
      x_inf = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
      y_inf = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
      x_z   = (x[30:23] == 8'd0);
      y_z   = (y[30:23] == 8'd0);
      if (x[30:0] >= y[30:0]) begin
         big = x;
         sml = y;
      end else begin
         big = y;
         sml = x;
      end
      // 27-bit working mantissa: hidden bit, 23 fraction bits, guard, round, sticky
      mb = {1'b1, big[22:0], 3'b000};
      ms = {1'b1, sml[22:0], 3'b000};
      d  = big[30:23] - sml[30:23];
      if (d >= 8'd27) begin
         msh = 27'd1;
      end else begin
         msh    = ms >> d;
         msh[0] = msh[0] | (|(ms & ((27'd1 << d) - 27'd1)));
      end
      e        = 10'(big[30:23]);
      zero_res = 1'b0;
      if (big[31] == sml[31]) begin
         sum = {1'b0, mb} + {1'b0, msh};
         if (sum[27]) begin
            nrm    = sum[27:1];
            nrm[0] = sum[1] | sum[0];
            e      = e + 10'sd1;
         end else begin
            nrm = sum[26:0];
         end
      end else begin
         nrm      = mb - msh;
         zero_res = (nrm == 27'd0);
         lz       = 5'd0;
         for (int i = 0; i < 27; i++) begin
            if (nrm[i]) lz = 5'(26 - i);
         end
         nrm = nrm << lz;
         e   = e - 10'(lz);
      end
      r = {1'b0, nrm[26:3]} + {24'd0, nrm[2] & ((|nrm[1:0]) | nrm[3])};
      if (r[24]) begin
         e = e + 10'sd1;
         m = r[23:1];
      end else begin
         m = r[22:0];
      end
      if (x_nan || y_nan || (x_inf && y_inf && (x[31] != y[31]))) res = 32'h7FC0_0000;
      else if (x_inf)        res = x;
      else if (y_inf)        res = y;
      else if (x_z && y_z)   res = {x[31] & y[31], 31'd0};
      else if (x_z)          res = y;
      else if (y_z)          res = x;
      else if (zero_res)     res = FP_ZERO;
      else if (e >= 10'sd255) res = {big[31], 8'hFF, 23'd0};
      else if (e <= 10'sd0)  res = {big[31], 31'd0};
      else                   res = {big[31], e[7:0], m};
      return res;
   endfunction

   // next accumulator value: clear wins over accumulate
   always_comb begin
      acc_d = acc_q;
      if (clr)     acc_d = FP_ZERO;
      else if (en) acc_d = fp_add(acc_q, fp_mul(a, b));
   end

   // accumulator register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc_q <= FP_ZERO;
      else        acc_q <= acc_d;
   end

   assign acc = acc_q;

endmodule

// File: rtl/matmul_lanes_seq.sv
// Lane-parallel sequential float32 matrix multiplier R = A x B (B given
// transposed). LANES result columns of one row are accumulated together,
// one MAC per lane per cycle; operands are captured at the start handshake.
// Optional build macro MATMUL_SEQ_RELU_EN clamps negative results to +0.0.
module matmul_lanes_seq
   import matmul_lanes_seq_pkg::*;
#(
   parameter int L     = 1,
   parameter int M     = 1,
   parameter int N     = 1,
   parameter int LANES = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [FP_W*L*M-1:0] A,
   input  logic [FP_W*N*M-1:0] B_T,
   output logic [FP_W*L*N-1:0] result,
   output logic                busy,
   output logic                done
);

   localparam int G  = ceil_div(N, LANES);
   localparam int RW = (L > 1) ? $clog2(L) : 1;
   localparam int KW = (M > 1) ? $clog2(M) : 1;
   localparam int CW = $clog2(N + LANES) + 1;

   state_e                state_q, state_d;
   logic [RW-1:0]         row_q, row_d;
   logic [KW-1:0]         k_q, k_d;
   logic [CW-1:0]         col_q, col_d;
   logic [FP_W*L*M-1:0]   a_q, a_d;
   logic [FP_W*N*M-1:0]   bt_q, bt_d;
   logic [FP_W*L*N-1:0]   result_q, result_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  lane_clr, lane_en;
   logic [FP_W-1:0]       a_elem;
   logic [FP_W-1:0]       lane_b   [LANES];
   logic [FP_W-1:0]       lane_acc [LANES];

   // operand fetch: A[row][k] shared, B_T[col_base+l][k] per lane (masked lanes see 0)
   always_comb begin
      a_elem = a_q[FP_W*(M*int'(row_q) + int'(k_q)) +: FP_W];
      for (int l = 0; l < LANES; l++) begin
         lane_b[l] = FP_ZERO;
         if (int'(col_q) + l < N)
            lane_b[l] = bt_q[FP_W*(M*(int'(col_q) + l) + int'(k_q)) +: FP_W];
      end
   end

   assign lane_clr = ((state_q == S_IDLE) && start) || (state_q == S_STORE);
   assign lane_en  = (state_q == S_MAC);

   for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
      fp_mac_lane u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (lane_clr),
         .en    (lane_en),
         .a     (a_elem),
         .b     (lane_b[gl]),
         .acc   (lane_acc[gl])
      );
   end

   // FSM next state, counters, operand capture and result write-back
   always_comb begin
      int              idx;
      logic [FP_W-1:0] v;
      idx      = 0;
      v        = FP_ZERO;
      state_d  = state_q;
      row_d    = row_q;
      k_d      = k_q;
      col_d    = col_q;
      a_d      = a_q;
      bt_d     = bt_q;
      result_d = result_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = A;
               bt_d    = B_T;
               row_d   = '0;
               col_d   = '0;
               k_d     = '0;
               busy_d  = 1'b1;
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            k_d = k_q + KW'(1);
            if (int'(k_q) == M - 1) begin
               k_d     = '0;
               state_d = S_STORE;
            end
         end
         S_STORE: begin
            for (int l = 0; l < LANES; l++) begin
               if (int'(col_q) + l < N) begin
                  idx = N*int'(row_q) + int'(col_q) + l;
                  v   = lane_acc[l];
`ifdef MATMUL_SEQ_RELU_EN
                  if (v[FP_W-1]) v = FP_ZERO;
`endif
                  result_d[FP_W*idx +: FP_W] = v;
               end
            end
            k_d     = '0;
            state_d = S_MAC;
            if (int'(col_q) == (G - 1) * LANES) begin
               col_d = '0;
               row_d = row_q + RW'(1);
               if (int'(row_q) == L - 1) begin
                  row_d   = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               col_d = col_q + CW'(LANES);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state, counters, captured operands and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         row_q    <= '0;
         k_q      <= '0;
         col_q    <= '0;
         a_q      <= '0;
         bt_q     <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         k_q      <= k_d;
         col_q    <= col_d;
         a_q      <= a_d;
         bt_q     <= bt_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign result = result_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule
